data_mem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory load/store port: accepts one

---
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core's data port and the
// data-memory responder.
interface data_mem_responder_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY cycles,
// performs the byte/half/word access and holds the response until it is taken.
//
// state    | meaning
// S_IDLE   | ready for a request
// S_WAIT   | counting down the programmed wait cycles
// S_ACCESS | check request, commit store, register response
// S_RESP   | response presented until consumer accepts
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [WORDS];

  logic [31:0]       rd_word;
  logic [15:0]       rd_half;
  logic [7:0]        rd_byte;
  logic [31:0]       ld_data;
  logic [31:0]       wr_data;
  logic [3:0]        lane_en;
  logic              acc_err;
  logic              mem_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; only the addressed lanes are written.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[addr_q[ADDR_W-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem_q[addr_q[ADDR_W-1:2]];
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (addr_q[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase

    acc_err = 1'b0;
    ld_data = '0;
    lane_en = '0;
    wr_data = wdata_q;
    case (f3_q)
      3'b000: begin
        ld_data = {{24{rd_byte[7]}}, rd_byte};
        lane_en = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        acc_err = addr_q[0];
        ld_data = {{16{rd_half[15]}}, rd_half};
        lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        acc_err = |addr_q[1:0];
        ld_data = rd_word;
        lane_en = 4'b1111;
      end
      // Unsigned codes exist only for loads.
      3'b100: begin
        acc_err = we_q;
        ld_data = {24'b0, rd_byte};
      end
      3'b101: begin
        acc_err = we_q | addr_q[0];
        ld_data = {16'b0, rd_half};
      end
      default: acc_err = 1'b1;
    endcase
    mem_wr = (state_q == S_ACCESS) && we_q && !acc_err;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        err_d   = acc_err;
        rdata_d = (acc_err || we_q) ? 32'd0 : ld_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with LATENCY=2, one with
// LATENCY=0, sharing clock/reset; sel0 steers the request/response channels.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel0 = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_ready = 1'b0;
  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(10)) if2 ();
  data_mem_responder_if #(.ADDR_W(10)) if0 ();

  assign if2.req_valid  = req_valid & ~sel0;
  assign if0.req_valid  = req_valid & sel0;
  assign if2.rsp_ready  = rsp_ready & ~sel0;
  assign if0.rsp_ready  = rsp_ready & sel0;
  assign if2.req_we     = req_we;
  assign if0.req_we     = req_we;
  assign if2.req_addr   = req_addr;
  assign if0.req_addr   = req_addr;
  assign if2.req_wdata  = req_wdata;
  assign if0.req_wdata  = req_wdata;
  assign if2.req_funct3 = req_funct3;
  assign if0.req_funct3 = req_funct3;
  assign m_req_ready = sel0 ? if0.req_ready : if2.req_ready;
  assign m_rsp_valid = sel0 ? if0.rsp_valid : if2.rsp_valid;
  assign m_rsp_rdata = sel0 ? if0.rsp_rdata : if2.rsp_rdata;
  assign m_rsp_err   = sel0 ? if0.rsp_err   : if2.rsp_err;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  data_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3);
    int n = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    while (!m_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!m_req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout req_ready=%b required 1", m_req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // lat counts edges from the accepting edge until the edge at which the
  // consumer first samples rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m_rsp_valid && lat < 50);
    if (!m_rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout rsp_valid=%b required 1", m_rsp_valid);
    end
  endtask

  task automatic xfer(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic err,
                      output int lat);
    issue(we, addr, wd, f3);
    wait_rsp(lat);
    rd = m_rsp_rdata; err = m_rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b required 0", m_rsp_valid); end
    checks++; if (m_rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata got %h required 0", m_rsp_rdata); end
    checks++; if (m_rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b required 0", m_rsp_err); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if2.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_l2 got %b required 1", if2.req_ready); end
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_l0 got %b required 1", if0.req_ready); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic err; int lat;
    xfer(1'b1, 10'h010, 32'hDEADBEEF, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL sw_rsp got %h/%b required 00000000/0", rd, err); end
    checks++; if (lat != 4) begin errors++; $display("FAIL sw_latency got %0d required 4", lat); end
    xfer(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL lw_010 got %h/%b required deadbeef/0", rd, err); end
    checks++; if (lat != 4) begin errors++; $display("FAIL lw_latency got %0d required 4", lat); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic err; int lat;
    xfer(1'b1, 10'h010, 32'h0, 3'b010, rd, err, lat);
    xfer(1'b1, 10'h013, 32'h12345680, 3'b000, rd, err, lat);
    checks++; if (rd !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL sb_rsp got %h/%b required 00000000/0", rd, err); end
    xfer(1'b0, 10'h013, 32'h0, 3'b000, rd, err, lat);
    checks++; if (rd !== 32'hFFFFFF80 || err !== 1'b0) begin errors++; $display("FAIL lb_013 got %h/%b required ffffff80/0", rd, err); end
    xfer(1'b0, 10'h013, 32'h0, 3'b100, rd, err, lat);
    checks++; if (rd !== 32'h00000080 || err !== 1'b0) begin errors++; $display("FAIL lbu_013 got %h/%b required 00000080/0", rd, err); end
    xfer(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL lw_after_sb got %h required 80000000", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic err; int lat;
    xfer(1'b1, 10'h020, 32'h11223344, 3'b010, rd, err, lat);
    xfer(1'b1, 10'h022, 32'hABCD8001, 3'b001, rd, err, lat);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sh_err got %b required 0", err); end
    xfer(1'b0, 10'h022, 32'h0, 3'b001, rd, err, lat);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_022 got %h required ffff8001", rd); end
    xfer(1'b0, 10'h022, 32'h0, 3'b101, rd, err, lat);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_022 got %h required 00008001", rd); end
    xfer(1'b0, 10'h020, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'h80013344) begin errors++; $display("FAIL lw_after_sh got %h required 80013344", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic err; int lat;
    xfer(1'b0, 10'h002, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'd0 || err !== 1'b1) begin errors++; $display("FAIL lw_misaligned got %h/%b required 00000000/1", rd, err); end
    xfer(1'b1, 10'h011, 32'hCAFEF00D, 3'b010, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sw_misaligned_err got %b required 1", err); end
    xfer(1'b1, 10'h010, 32'h000000FF, 3'b100, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sbu_store_err got %b required 1", err); end
    xfer(1'b0, 10'h010, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'h80000000) begin errors++; $display("FAIL word_untouched got %h required 80000000", rd); end
    xfer(1'b0, 10'h010, 32'h0, 3'b011, rd, err, lat);
    checks++; if (rd !== 32'd0 || err !== 1'b1) begin errors++; $display("FAIL funct3_011 got %h/%b required 00000000/1", rd, err); end
    xfer(1'b0, 10'h021, 32'h0, 3'b001, rd, err, lat);
    checks++; if (rd !== 32'd0 || err !== 1'b1) begin errors++; $display("FAIL lh_odd got %h/%b required 00000000/1", rd, err); end
  endtask

  task automatic test_stall;
    int lat;
    issue(1'b0, 10'h010, 32'h0, 3'b010);
    wait_rsp(lat);
    req_we = 1'b0; req_addr = 10'h020; req_funct3 = 3'b010; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== 32'h80000000) begin
        errors++; $display("FAIL stall_hold cyc%0d got %b/%h required 1/80000000", i, m_rsp_valid, m_rsp_rdata);
      end
      checks++; if (m_req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cyc%0d got %b required 0", i, m_req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    checks++; if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got ready=%b valid=%b required 1/0", m_req_ready, m_rsp_valid);
    end
    checks++; if (m_rsp_rdata !== 32'd0) begin errors++; $display("FAIL stall_clear got %h required 0", m_rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic err; int lat; bit seen;
    xfer(1'b1, 10'h030, 32'h5555AAAA, 3'b010, rd, err, lat);
    issue(1'b1, 10'h030, 32'h00001234, 3'b010);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (m_rsp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wait_rst_rsp got valid=%b required 0", seen); end
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL wait_rst_ready got %b required 1", m_req_ready); end
    xfer(1'b0, 10'h030, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL store_discarded got %h required 5555aaaa", rd); end
    issue(1'b1, 10'h034, 32'h13572468, 3'b010);
    wait_rsp(lat);
    rst = 1'b0;
    #1;
    checks++; if (m_rsp_valid !== 1'b0 || m_rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL resp_rst got %b/%h required 0/00000000", m_rsp_valid, m_rsp_rdata);
    end
    @(negedge clk); rst = 1'b1;
    xfer(1'b0, 10'h034, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'h13572468) begin errors++; $display("FAIL store_committed got %h required 13572468", rd); end
  endtask

  task automatic test_lat0;
    logic [31:0] rd; logic err; int lat;
    sel0 = 1'b1;
    xfer(1'b1, 10'h030, 32'h0BADC0DE, 3'b010, rd, err, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL l0_sw_latency got %0d required 2", lat); end
    xfer(1'b0, 10'h030, 32'h0, 3'b010, rd, err, lat);
    checks++; if (rd !== 32'h0BADC0DE || lat != 2) begin errors++; $display("FAIL l0_lw got %h lat %0d required 0badc0de lat 2", rd, lat); end
    xfer(1'b0, 10'h031, 32'h0, 3'b000, rd, err, lat);
    checks++; if (rd !== 32'hFFFFFFC0) begin errors++; $display("FAIL l0_lb_031 got %h required ffffffc0", rd); end
    sel0 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_stall;
    test_reset_mid;
    test_lat0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
